// File: rtl/lcd_st7789v3_rx_pkg.sv
// rtl/lcd_st7789v3_rx_pkg.sv - command codes and decoder state type for the ST7789V3 responder
package lcd_st7789v3_rx_pkg;

    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_SLPIN   = 8'h10;
    localparam logic [7:0] CMD_SLPOUT  = 8'h11;
    localparam logic [7:0] CMD_NORON   = 8'h13;
    localparam logic [7:0] CMD_INVOFF  = 8'h20;
    localparam logic [7:0] CMD_INVON   = 8'h21;
    localparam logic [7:0] CMD_DISPOFF = 8'h28;
    localparam logic [7:0] CMD_DISPON  = 8'h29;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_RASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARG,
        ST_RAMWR,
        ST_IGNORE
    } dec_state_t;

    // Parameterless commands return to IDLE so that a stray data byte is flagged;
    // unknown commands swallow their parameters silently.
    function automatic dec_state_t cmd_next_state(input logic [7:0] code);
        dec_state_t ns;
        case (code)
            CMD_SWRESET, CMD_SLPIN, CMD_SLPOUT, CMD_NORON,
            CMD_INVOFF, CMD_INVON, CMD_DISPOFF, CMD_DISPON: ns = ST_IDLE;
            CMD_CASET, CMD_RASET:                           ns = ST_ARG;
            CMD_RAMWR:                                      ns = ST_RAMWR;
            default:                                        ns = ST_IGNORE;
        endcase
        return ns;
    endfunction

endpackage

// File: rtl/lcd_spi_deser.sv
// rtl/lcd_spi_deser.sv - pin synchronizers, SCL edge detect and 8-bit byte deserializer
module lcd_spi_deser #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_cs,
    input  logic       lcd_scl,
    input  logic       lcd_sd,
    input  logic       lcd_rs,
    input  logic       lcd_rst,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_rs,
    output logic       link_rst
);

    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sd_sync;
    logic [SYNC_STAGES-1:0] rs_sync;
    logic [SYNC_STAGES-1:0] rst_sync;
    logic                   scl_q;
    logic [7:0]             shift_reg;
    logic [2:0]             bit_cnt;

    logic cs_s;
    logic scl_s;
    logic sd_s;
    logic rs_s;
    logic rst_n_s;
    logic scl_rise;

    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign scl_s    = scl_sync[SYNC_STAGES-1];
    assign sd_s     = sd_sync[SYNC_STAGES-1];
    assign rs_s     = rs_sync[SYNC_STAGES-1];
    assign rst_n_s  = rst_sync[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_q;
    assign link_rst = ~rst_n_s;

    // Synchronizer chains; active-low pins idle at their inactive level out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sync  <= '1;
            scl_sync <= '0;
            sd_sync  <= '0;
            rs_sync  <= '0;
            rst_sync <= '1;
            scl_q    <= 1'b0;
        end else begin
            cs_sync  <= (cs_sync  << 1) | SYNC_STAGES'(lcd_cs);
            scl_sync <= (scl_sync << 1) | SYNC_STAGES'(lcd_scl);
            sd_sync  <= (sd_sync  << 1) | SYNC_STAGES'(lcd_sd);
            rs_sync  <= (rs_sync  << 1) | SYNC_STAGES'(lcd_rs);
            rst_sync <= (rst_sync << 1) | SYNC_STAGES'(lcd_rst);
            scl_q    <= scl_s;
        end
    end

    // MSB-first shift on sampled SCL rising edges; CS high drops a partial byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg  <= 8'h00;
            bit_cnt    <= 3'd0;
            byte_valid <= 1'b0;
            byte_data  <= 8'h00;
            byte_rs    <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            if (!rst_n_s) begin
                shift_reg <= 8'h00;
                bit_cnt   <= 3'd0;
            end else if (cs_s) begin
                bit_cnt <= 3'd0;
            end else if (scl_rise) begin
                shift_reg <= {shift_reg[6:0], sd_s};
                if (bit_cnt == 3'd7) begin
                    byte_valid <= 1'b1;
                    byte_data  <= {shift_reg[6:0], sd_s};
                    byte_rs    <= rs_s;
                    bit_cnt    <= 3'd0;
                end else begin
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end
        end
    end

endmodule

// File: rtl/lcd_st7789v3_rx.sv
// rtl/lcd_st7789v3_rx.sv - ST7789V3 link responder: command decode, address window, pixel stream
module lcd_st7789v3_rx
    import lcd_st7789v3_rx_pkg::*;
#(
    parameter int DISP_WIDTH  = 135,
    parameter int DISP_HEIGHT = 240,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lcd_cs,
    input  logic        lcd_scl,
    input  logic        lcd_sd,
    input  logic        lcd_rs,
    input  logic        lcd_rst,
    output logic        cmd_valid,
    output logic [7:0]  cmd_code,
    output logic        pix_valid,
    output logic [15:0] pix_x,
    output logic [15:0] pix_y,
    output logic [15:0] pix_data,
    output logic [15:0] xs,
    output logic [15:0] xe,
    output logic [15:0] ys,
    output logic [15:0] ye,
    output logic        sleep_out,
    output logic        disp_on,
    output logic        inv_on,
    output logic        err
);

    localparam logic [15:0] XE_DEFAULT = 16'(DISP_WIDTH - 1);
    localparam logic [15:0] YE_DEFAULT = 16'(DISP_HEIGHT - 1);
    localparam logic [15:0] X_LIMIT    = 16'(DISP_WIDTH);
    localparam logic [15:0] Y_LIMIT    = 16'(DISP_HEIGHT);

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_rs;
    logic       link_rst;

    dec_state_t state;
    dec_state_t state_next;

    logic [2:0]  arg_cnt;
    logic [23:0] arg_buf;
    logic        arg_row;
    logic        arg_done;
    logic [15:0] px;
    logic [15:0] py;
    logic        hi_pend;
    logic [7:0]  hi_byte;

    logic [15:0] arg_s;
    logic [15:0] arg_e;
    logic        arg_ok;

    lcd_spi_deser #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_deser (
        .clk        (clk),
        .rst        (rst),
        .lcd_cs     (lcd_cs),
        .lcd_scl    (lcd_scl),
        .lcd_sd     (lcd_sd),
        .lcd_rs     (lcd_rs),
        .lcd_rst    (lcd_rst),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_rs    (byte_rs),
        .link_rst   (link_rst)
    );

    // Window candidate formed from the three buffered bytes plus the byte arriving now.
    always_comb begin
        arg_s  = arg_buf[23:8];
        arg_e  = {arg_buf[7:0], byte_data};
        arg_ok = (arg_s <= arg_e) && (arg_e < (arg_row ? Y_LIMIT : X_LIMIT));
    end

    // Decoder state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else if (link_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: commands pick the state outright, the 4th argument byte ends ARG.
    always_comb begin
        state_next = state;
        if (byte_valid) begin
            if (!byte_rs) begin
                state_next = cmd_next_state(byte_data);
            end else if (state == ST_ARG && arg_cnt == 3'd3) begin
                state_next = ST_IGNORE;
            end
        end
    end

    // Window, flags, argument collection, pixel pairing and pulse outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_valid <= 1'b0;
            cmd_code  <= 8'h00;
            pix_valid <= 1'b0;
            pix_x     <= 16'd0;
            pix_y     <= 16'd0;
            pix_data  <= 16'd0;
            xs        <= 16'd0;
            xe        <= XE_DEFAULT;
            ys        <= 16'd0;
            ye        <= YE_DEFAULT;
            sleep_out <= 1'b0;
            disp_on   <= 1'b0;
            inv_on    <= 1'b0;
            err       <= 1'b0;
            arg_cnt   <= 3'd0;
            arg_buf   <= 24'd0;
            arg_row   <= 1'b0;
            arg_done  <= 1'b0;
            px        <= 16'd0;
            py        <= 16'd0;
            hi_pend   <= 1'b0;
            hi_byte   <= 8'h00;
        end else begin
            cmd_valid <= 1'b0;
            pix_valid <= 1'b0;
            err       <= 1'b0;
            if (link_rst) begin
                cmd_code  <= 8'h00;
                pix_x     <= 16'd0;
                pix_y     <= 16'd0;
                pix_data  <= 16'd0;
                xs        <= 16'd0;
                xe        <= XE_DEFAULT;
                ys        <= 16'd0;
                ye        <= YE_DEFAULT;
                sleep_out <= 1'b0;
                disp_on   <= 1'b0;
                inv_on    <= 1'b0;
                arg_cnt   <= 3'd0;
                arg_done  <= 1'b0;
                hi_pend   <= 1'b0;
            end else if (byte_valid && !byte_rs) begin
                cmd_valid <= 1'b1;
                cmd_code  <= byte_data;
                arg_cnt   <= 3'd0;
                arg_done  <= 1'b0;
                hi_pend   <= 1'b0;
                case (byte_data)
                    CMD_SWRESET: begin
                        xs        <= 16'd0;
                        xe        <= XE_DEFAULT;
                        ys        <= 16'd0;
                        ye        <= YE_DEFAULT;
                        sleep_out <= 1'b0;
                        disp_on   <= 1'b0;
                        inv_on    <= 1'b0;
                    end
                    CMD_SLPIN:   sleep_out <= 1'b0;
                    CMD_SLPOUT:  sleep_out <= 1'b1;
                    CMD_INVOFF:  inv_on    <= 1'b0;
                    CMD_INVON:   inv_on    <= 1'b1;
                    CMD_DISPOFF: disp_on   <= 1'b0;
                    CMD_DISPON:  disp_on   <= 1'b1;
                    CMD_CASET:   arg_row   <= 1'b0;
                    CMD_RASET:   arg_row   <= 1'b1;
                    CMD_RAMWR: begin
                        px <= xs;
                        py <= ys;
                    end
                    default: ;
                endcase
            end else if (byte_valid) begin
                case (state)
                    ST_IDLE: err <= 1'b1;
                    ST_ARG: begin
                        if (arg_cnt == 3'd3) begin
                            arg_done <= 1'b1;
                            if (arg_ok) begin
                                if (arg_row) begin
                                    ys <= arg_s;
                                    ye <= arg_e;
                                end else begin
                                    xs <= arg_s;
                                    xe <= arg_e;
                                end
                            end else begin
                                err <= 1'b1;
                            end
                        end else begin
                            arg_buf <= {arg_buf[15:0], byte_data};
                            arg_cnt <= arg_cnt + 3'd1;
                        end
                    end
                    ST_RAMWR: begin
                        if (!hi_pend) begin
                            hi_byte <= byte_data;
                            hi_pend <= 1'b1;
                        end else begin
                            hi_pend   <= 1'b0;
                            pix_valid <= 1'b1;
                            pix_x     <= px;
                            pix_y     <= py;
                            pix_data  <= {hi_byte, byte_data};
                            if (px == xe) begin
                                px <= xs;
                                py <= (py == ye) ? ys : py + 16'd1;
                            end else begin
                                px <= px + 16'd1;
                            end
                        end
                    end
                    // Extra bytes after a complete CASET/RASET are a violation.
                    ST_IGNORE: err <= arg_done;
                    default: ;
                endcase
            end
        end
    end

endmodule
